// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master between two requesters.
// A winning command is latched and then presented to the master for a fixed
// transaction length. Completion is signalled back to the owning requester.
module apb_req_arbiter #(
  parameter int unsigned ADDRESS     = 8,
  parameter int unsigned DATA        = 8,
  parameter int unsigned XFER_CYCLES = 3
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req0,
  input  logic               req1,
  input  logic               rw0,
  input  logic               rw1,
  input  logic [ADDRESS-1:0] addr0,
  input  logic [ADDRESS-1:0] addr1,
  input  logic [DATA-1:0]    wdata0,
  input  logic [DATA-1:0]    wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [DATA-1:0]    rdata,
  output logic               transfer,
  output logic               READ_WRITE,
  output logic [ADDRESS-1:0] apb_write_paddr,
  output logic [ADDRESS-1:0] apb_read_paddr,
  output logic [DATA-1:0]    apb_write_data,
  input  logic [DATA-1:0]    apb_read_data_out
);

  localparam int unsigned     CW       = $clog2(XFER_CYCLES);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XFER_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic               owner;
  logic               ptr;
  logic               pick;
  logic [ADDRESS-1:0] paddr;

  // Winner when a request is present: the pointer breaks ties, otherwise the lone requester wins
  always_comb pick = (req0 && req1) ? ptr : req1;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: WAIT leaves when the down-counter is about to hit zero
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake pulses decoded from state and owner
  always_comb begin
    transfer = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    if (state == START) begin
      transfer = 1'b1;
      gnt0     = ~owner;
      gnt1     = owner;
    end
    if (state == DONE) begin
      done0 = ~owner;
      done1 = owner;
    end
  end

  // Command latch, transaction counter, read capture and round-robin pointer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt            <= '0;
      owner          <= 1'b0;
      ptr            <= 1'b0;
      READ_WRITE     <= 1'b0;
      paddr          <= '0;
      apb_write_data <= '0;
      rdata          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner          <= pick;
            READ_WRITE     <= pick ? rw1 : rw0;
            paddr          <= pick ? addr1 : addr0;
            apb_write_data <= pick ? wdata1 : wdata0;
          end
        end
        START: cnt <= CNT_LOAD;
        WAIT: begin
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST && !READ_WRITE) rdata <= apb_read_data_out;
        end
        DONE: ptr <= ~owner;
        default: ;
      endcase
    end
  end

  assign apb_write_paddr = paddr;
  assign apb_read_paddr  = paddr;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized and directed bench for apb_req_arbiter against a cycle-number
// based transaction model with a simple memory-backed APB slave stub.
module tb_apb_req_arbiter;

  localparam int XFER = 3;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic [1:0] req;
  logic [1:0] rw;
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic       gnt0, gnt1, done0, done1, transfer, READ_WRITE;
  logic [7:0] rdata, apb_write_paddr, apb_read_paddr, apb_write_data, apb_read_data_out;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter #(.ADDRESS(8), .DATA(8), .XFER_CYCLES(XFER)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req[0]), .req1(req[1]), .rw0(rw[0]), .rw1(rw[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data), .apb_read_data_out(apb_read_data_out)
  );

  // Slave stub: writes land at the end of the transfer cycle, reads are combinational
  logic [7:0] slave_mem [256];
  bit         slave_wr  [256];
  always @(posedge PCLK) begin
    if (transfer && READ_WRITE) begin
      slave_mem[apb_write_paddr] <= apb_write_data;
      slave_wr[apb_write_paddr]  <= 1'b1;
    end
  end
  always_comb apb_read_data_out = slave_wr[apb_read_paddr] ? slave_mem[apb_read_paddr]
                                                           : (apb_read_paddr ^ 8'hA5);

  // Reference model: transactions described by their start cycle number
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         m_active, m_owner, m_ptr, m_rw;
  int         m_start;
  logic [7:0] m_addr, m_wdata, e_rdata;
  logic [7:0] ref_mem [256];
  bit         ref_wr  [256];
  cmd_t       q0[$], q1[$];
  bit         gaps, withdraw;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_ptr = 0; m_rw = 0; m_start = 0;
    m_addr = '0; m_wdata = '0; e_rdata = '0;
  endtask

  // Applied at the clock edge that begins cycle cyc
  task automatic model_edge();
    bit w;
    if (!PRESETn) return;
    if (m_active && cyc == m_start + XFER && !m_rw)
      e_rdata = ref_wr[m_addr] ? ref_mem[m_addr] : (m_addr ^ 8'hA5);
    if (m_active && cyc == m_start + XFER + 1) m_ptr = !m_owner;
    if ((!m_active || cyc - 1 >= m_start + XFER + 1) && (req[0] || req[1])) begin
      w        = (req[0] && req[1]) ? m_ptr : req[1];
      m_owner  = w;
      m_start  = cyc;
      m_active = 1;
      m_rw     = rw[w];
      m_addr   = addr[w];
      m_wdata  = wdata[w];
      if (m_rw) begin
        ref_mem[m_addr] = m_wdata;
        ref_wr[m_addr]  = 1;
      end
    end
  endtask

  task automatic compare();
    logic [4:0] e_ctl;
    bit g, d;
    g = m_active && cyc == m_start;
    d = m_active && cyc == m_start + XFER;
    e_ctl = {g && !m_owner, g && m_owner, d && !m_owner, d && m_owner, g};
    check_eq("ctl{g0,g1,d0,d1,xfer}", 32'({gnt0, gnt1, done0, done1, transfer}), 32'(e_ctl));
    check_eq("READ_WRITE", 32'(READ_WRITE), 32'(m_rw));
    check_eq("write_paddr", 32'(apb_write_paddr), 32'(m_addr));
    check_eq("read_paddr", 32'(apb_read_paddr), 32'(m_addr));
    check_eq("write_data", 32'(apb_write_data), 32'(m_wdata));
    check_eq("rdata", 32'(rdata), 32'(e_rdata));
  endtask

  task automatic load(input int r);
    cmd_t c;
    if (r == 0) c = q0.pop_front();
    else        c = q1.pop_front();
    req[r] = 1'b1; rw[r] = c.rw; addr[r] = c.addr; wdata[r] = c.data;
  endtask

  task automatic scramble(input int r);
    rw[r] = 1'($urandom); addr[r] = 8'($urandom); wdata[r] = 8'($urandom);
  endtask

  // Requesters: hold a command until granted, then take the next one or go quiet
  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      int pend;
      pend = (r == 0) ? q0.size() : q1.size();
      if (m_active && cyc == m_start && m_owner == r[0]) begin
        if (pend > 0) load(r);
        else begin req[r] = 1'b0; scramble(r); end
      end else if (!req[r]) begin
        if (pend > 0 && (!gaps || $urandom_range(0, 2) == 0)) load(r);
      end else if (withdraw && $urandom_range(0, 19) == 0) begin
        req[r] = 1'b0; scramble(r);
      end
    end
  endtask

  task automatic run_cycle();
    @(posedge PCLK);
    cyc++;
    model_edge();
    #1;
    drive();
    @(negedge PCLK);
    compare();
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && req == 2'b00 &&
             (!m_active || cyc > m_start + XFER))) begin
      if (n >= maxc) begin
        check_eq("idle_timeout", 32'(q0.size() + q1.size() + int'(req != 0)), 32'd0);
        return;
      end
      run_cycle();
      n++;
    end
  endtask

  // Called just after a falling-edge compare; asserts reset away from the rising edge
  task automatic do_reset();
    #2;
    PRESETn = 1'b0;
    req = '0;
    q0.delete(); q1.delete();
    model_reset();
    #1;
    compare();
    run_cycle();
    run_cycle();
  endtask

  task automatic release_reset();
    #1 PRESETn = 1'b1;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.rw = 1'($urandom); c.addr = 8'($urandom_range(0, 7)); c.data = 8'($urandom);
    return c;
  endfunction

  initial begin
    req = '0; rw = '0; gaps = 0; withdraw = 0;
    for (int r = 0; r < 2; r++) begin addr[r] = '0; wdata[r] = '0; end
    model_reset();
    repeat (2) @(negedge PCLK);
    compare();
    release_reset();

    // Single write from requester 0
    q0.push_back('{rw: 1'b1, addr: 8'd2, data: 8'd6});
    wait_idle(40);

    // Write then read back the same address via the other requester
    q0.push_back('{rw: 1'b1, addr: 8'd15, data: 8'd3});
    wait_idle(40);
    q1.push_back('{rw: 1'b0, addr: 8'd15, data: 8'd0});
    wait_idle(40);
    check_eq("t4_rdata", 32'(rdata), 32'd3);
    q0.push_back('{rw: 1'b1, addr: 8'd9, data: 8'd77});
    wait_idle(40);
    check_eq("t4_rdata_hold", 32'(rdata), 32'd3);

    // Both requesting from reset: requester 0 first, then strict alternation
    do_reset();
    release_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{rw: 1'b1, addr: 8'(32 + i), data: 8'(i + 1)});
      q1.push_back('{rw: 1'b0, addr: 8'(32 + i), data: 8'h00});
    end
    run_cycle();
    run_cycle();
    check_eq("t3_first_gnt0", 32'({gnt0, gnt1}), 32'b10);
    wait_idle(80);

    // Reset in the middle of a transaction, then a fresh req1
    q0.push_back('{rw: 1'b1, addr: 8'd40, data: 8'd99});
    for (int i = 0; i < 20 && !(m_active && cyc == m_start + 1); i++) run_cycle();
    check_eq("t5_in_wait", 32'(m_active && cyc == m_start + 1), 32'd1);
    do_reset();
    q1.push_back('{rw: 1'b0, addr: 8'd15, data: 8'd0});
    run_cycle();
    release_reset();
    run_cycle();
    check_eq("t5_gnt1_first_edge", 32'({gnt1, transfer}), 32'b11);
    wait_idle(40);

    // Requester 0 alone, back-to-back
    q0.push_back('{rw: 1'b0, addr: 8'd16, data: 8'd0});
    q0.push_back('{rw: 1'b1, addr: 8'd20, data: 8'd11});
    q0.push_back('{rw: 1'b0, addr: 8'd5, data: 8'd0});
    wait_idle(60);

    // Random traffic with gaps and silent withdrawals
    gaps = 1; withdraw = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && q0.size() < 3) q0.push_back(rand_cmd());
      if ($urandom_range(0, 3) == 0 && q1.size() < 3) q1.push_back(rand_cmd());
      run_cycle();
    end
    withdraw = 0;
    wait_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
